// File: rtl/reg_dump_reader.sv
// Walks a range of register-file addresses through a combinational read port
// and streams each word out LSB-first as bytes on a valid/ready interface.
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [7:0]            o_out_byte,
  output logic                  o_out_last
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_byte_idx;

  logic w_start_ok;
  logic w_count_zero;
  logic w_accept;
  logic w_word_done;
  logic w_more_words;

  // FIN behaves like IDLE for command acceptance so dumps can run back to back
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_count_zero = (i_count == '0);
  assign w_accept     = (r_state == S_SEND) && i_out_ready;
  assign w_word_done  = w_accept && (r_byte_idx == LAST_IDX);
  assign w_more_words = (r_remaining > REM_ONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (w_start_ok) begin
          w_state_next = w_count_zero ? S_FIN : S_FETCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_FETCH: w_state_next = S_SEND;
      S_SEND: begin
        if (w_word_done) begin
          w_state_next = w_more_words ? S_FETCH : S_FIN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // rd_addr is only reloaded on entry to FETCH, so it holds between fetches
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_byte_idx  <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= i_start_addr;
        r_remaining <= i_count;
        if (!w_count_zero) begin
          r_rd_addr <= i_start_addr;
        end
      end
      if (r_state == S_FETCH) begin
        r_shift    <= i_rd_data;
        r_byte_idx <= '0;
      end
      if (w_accept) begin
        r_shift    <= r_shift >> 8;
        r_byte_idx <= r_byte_idx + IDX_ONE;
        if (w_word_done) begin
          r_remaining <= r_remaining - REM_ONE;
          r_addr      <= r_addr + ADDR_ONE;
          if (w_more_words) begin
            r_rd_addr <= r_addr + ADDR_ONE;
          end
        end
      end
    end
  end

  assign o_busy      = (r_state == S_FETCH) || (r_state == S_SEND);
  assign o_done      = (r_state == S_FIN);
  assign o_rd_addr   = r_rd_addr;
  assign o_out_valid = (r_state == S_SEND);
  assign o_out_byte  = r_shift[7:0];
  assign o_out_last  = (r_state == S_SEND) && (r_remaining == REM_ONE) &&
                       (r_byte_idx == LAST_IDX);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table of dump commands plus hand-written
// sequences; bytes and read addresses are checked against a scoreboard.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  logic [31:0] regfile [32];

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [5:0] cnt;
    bit         bp;
    int         exp_done;
    int         inj;
  } vec_t;

  exp_t       exp_q [$];
  logic [4:0] rd_q  [$];
  vec_t       vecs  [8];

  int n_vec  = 0;
  int n_fail = 0;

  bit         held_valid = 1'b0;
  logic [7:0] held_byte;
  logic       held_last;
  bit   [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  assign rd_data = regfile[rd_addr];

  reg_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_count      (count),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_byte   (out_byte),
    .o_out_last   (out_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent model: word at address i is 2*i
  task automatic push_expected(input logic [4:0] a, input logic [5:0] n);
    for (int k = 0; k < int'(n); k++) begin
      logic [4:0]  ad;
      logic [31:0] w;
      ad = a + 5'(k);
      w  = 32'(ad) * 2;
      rd_q.push_back(ad);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        e.b    = w[8*j +: 8];
        e.last = (k == int'(n) - 1) && (j == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    if (held_valid) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_byte", 32'(out_byte), 32'(held_byte));
      chk("stall_last", 32'(out_last), 32'(held_last));
    end
    held_valid = out_valid && !out_ready;
    held_byte  = out_byte;
    held_last  = out_last;
    if (busy && !out_valid) begin
      if (rd_q.size() == 0) chk("unexpected_fetch", 32'd1, 32'd0);
      else begin
        logic [4:0] ea;
        ea = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(ea));
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", 32'(out_byte), 32'hFFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("byte", 32'(out_byte), 32'(e.b));
        chk("last", 32'(out_last), 32'(e.last));
        $display("byte %02h last %0d (expected %02h/%0d)", out_byte, out_last, e.b, e.last);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int c_init, input int exp_done, input bit bp, input int inj);
    int c;
    bit seen;
    c = c_init;
    seen = 1'b0;
    while (!seen && c <= exp_done + 40) begin
      sample();
      chk("busy", 32'(busy), 32'((c >= 1) && (c < exp_done)));
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 32'(c), 32'(exp_done));
      end
      adv();
      c++;
      start = 1'b0;
      if (c == inj) begin
        start = 1'b1;
        start_addr = 5'd0;
        count = 6'd5;
      end
      out_ready = bp ? pat[c % 4] : 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("fetches_left", 32'(rd_q.size()), 32'd0);
    sample();
    chk("done_pulse", 32'(done), 32'd0);
    adv();
    out_ready = 1'b1;
  endtask

  task automatic run_dump(input vec_t v);
    start = 1'b1;
    start_addr = v.addr;
    count = v.cnt;
    out_ready = v.bp ? pat[0] : 1'b1;
    push_expected(v.addr, v.cnt);
    $display("dump addr=%0d count=%0d bp=%0d", v.addr, v.cnt, v.bp);
    wait_done(0, v.exp_done, v.bp, v.inj);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'(2 * i);
    vecs[0] = '{addr: 5'd3,  cnt: 6'd2,  bp: 1'b0, exp_done: 11,  inj: -1};
    vecs[1] = '{addr: 5'd31, cnt: 6'd2,  bp: 1'b0, exp_done: 11,  inj: -1};
    vecs[2] = '{addr: 5'd3,  cnt: 6'd2,  bp: 1'b1, exp_done: 17,  inj: -1};
    vecs[3] = '{addr: 5'd3,  cnt: 6'd2,  bp: 1'b0, exp_done: 11,  inj: 4};
    vecs[4] = '{addr: 5'd30, cnt: 6'd3,  bp: 1'b0, exp_done: 16,  inj: -1};
    vecs[5] = '{addr: 5'd10, cnt: 6'd1,  bp: 1'b1, exp_done: 9,   inj: -1};
    vecs[6] = '{addr: 5'd7,  cnt: 6'd0,  bp: 1'b0, exp_done: 1,   inj: -1};
    vecs[7] = '{addr: 5'd0,  cnt: 6'd32, bp: 1'b0, exp_done: 161, inj: -1};

    rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    adv();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_dump(vecs[i]);

    // count=0 followed by a start issued during the FIN cycle
    start = 1'b1; start_addr = 5'd7; count = 6'd0;
    sample();
    chk("z_busy0", 32'(busy), 32'd0);
    adv();
    start = 1'b1; start_addr = 5'd5; count = 6'd1;
    push_expected(5'd5, 6'd1);
    sample();
    chk("z_done1", 32'(done), 32'd1);
    chk("z_busy1", 32'(busy), 32'd0);
    chk("z_valid1", 32'(out_valid), 32'd0);
    adv();
    start = 1'b0;
    wait_done(1, 6, 1'b0, -1);

    // reset while the second byte is on the output
    start = 1'b1; start_addr = 5'd3; count = 6'd2;
    push_expected(5'd3, 6'd2);
    sample();
    adv(); start = 1'b0;
    sample();
    adv();
    sample();
    adv(); rst = 1'b1;
    sample();
    adv(); rst = 1'b0;
    sample();
    chk("ra_busy", 32'(busy), 32'd0);
    chk("ra_done", 32'(done), 32'd0);
    chk("ra_valid", 32'(out_valid), 32'd0);
    chk("ra_last", 32'(out_last), 32'd0);
    chk("ra_byte", 32'(out_byte), 32'd0);
    chk("ra_rd_addr", 32'(rd_addr), 32'd0);
    exp_q.delete();
    rd_q.delete();
    held_valid = 1'b0;
    adv();
    sample();
    chk("ra_done_next", 32'(done), 32'd0);
    adv();
    run_dump('{addr: 5'd1, cnt: 6'd1, bp: 1'b0, exp_done: 6, inj: -1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
